// File: rtl/battleship_pkg.sv
// Shared types for the two-player battleship controller: states, display codes, glyphs.
// Glyph patterns are active-low, bit 0 = segment a through bit 6 = segment g.
package battleship_pkg;

    typedef enum logic [2:0] {
        S_SETUP,
        S_TURN_A,
        S_TURN_B,
        S_WIN_A,
        S_WIN_B,
        S_DRAW
    } state_e;

    localparam logic [2:0] D_LOAD = 3'd0;
    localparam logic [2:0] D_FIRE = 3'd1;
    localparam logic [2:0] D_WAIT = 3'd2;
    localparam logic [2:0] D_WIN  = 3'd3;
    localparam logic [2:0] D_LOSE = 3'd4;
    localparam logic [2:0] D_DRAW = 3'd5;

    localparam logic [6:0] G_BLK = 7'h7F;
    localparam logic [6:0] G_L   = ~7'h38;
    localparam logic [6:0] G_O   = ~7'h3F;
    localparam logic [6:0] G_A   = ~7'h77;
    localparam logic [6:0] G_D   = ~7'h5E;
    localparam logic [6:0] G_F   = ~7'h71;
    localparam logic [6:0] G_I   = ~7'h06;
    localparam logic [6:0] G_R   = ~7'h50;
    localparam logic [6:0] G_E   = ~7'h79;
    localparam logic [6:0] G_W   = ~7'h3E;
    localparam logic [6:0] G_T   = ~7'h78;
    localparam logic [6:0] G_N   = ~7'h37;
    localparam logic [6:0] G_S   = ~7'h6D;

    // Digit 3 is the leftmost character of each word.
    function automatic logic [6:0] glyph(input logic [2:0] code,
                                         input logic [1:0] dig);
        logic [27:0] w;
        case (code)
            D_LOAD:  w = {G_L, G_O, G_A, G_D};
            D_FIRE:  w = {G_F, G_I, G_R, G_E};
            D_WAIT:  w = {G_W, G_A, G_I, G_T};
            D_WIN:   w = {G_BLK, G_W, G_I, G_N};
            D_LOSE:  w = {G_L, G_O, G_S, G_E};
            D_DRAW:  w = {G_D, G_R, G_A, G_W};
            default: w = {4{G_BLK}};
        endcase
        case (dig)
            2'd3:    return w[27:21];
            2'd2:    return w[20:14];
            2'd1:    return w[13:7];
            default: return w[6:0];
        endcase
    endfunction

endpackage

// File: rtl/battleship_if.sv
// Player-facing signal bundle of the battleship controller.
// master drives buttons and game status; slave is the controller.
interface battleship_if;

    logic       BTN1;
    logic       BTN2A;
    logic       BTN2B;
    logic       LivA;
    logic       LivB;
    logic       OKA;
    logic       OKB;
    logic       ST;
    logic       LDR1A;
    logic       LDR1B;
    logic       LDR2A;
    logic       LDR2B;
    logic [2:0] DispA;
    logic [2:0] DispB;
    logic [7:0] seg;
    logic [3:0] an;

    modport master (
        output BTN1, BTN2A, BTN2B, LivA, LivB, OKA, OKB,
        input  ST, LDR1A, LDR1B, LDR2A, LDR2B, DispA, DispB, seg, an
    );

    modport slave (
        input  BTN1, BTN2A, BTN2B, LivA, LivB, OKA, OKB,
        output ST, LDR1A, LDR1B, LDR2A, LDR2B, DispA, DispB, seg, an
    );

endinterface

// File: rtl/battleship_words2.sv
// Multiplexed 4-digit word display; built only with BATTLESHIP_SSEG_EN.
// Top two refresh-counter bits pick the digit, digit 3 leftmost.
`ifdef BATTLESHIP_SSEG_EN
module words2
    import battleship_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [2:0] wordSelect,
    output logic [7:0] seg,
    output logic [3:0] an
);

    logic [REFRESH_BITS-1:0] cnt_q;
    logic [1:0]              dig;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign dig = cnt_q[REFRESH_BITS-1 -: 2];
    assign an  = ~(4'b0001 << dig);
    assign seg = {1'b1, glyph(wordSelect, dig)};

endmodule
`endif

// File: rtl/battleship_fsm.sv
// Battleship turn controller: setup, alternating turns, win/lose/draw.
// BATTLESHIP_SSEG_EN adds the 7-segment driver showing player A's word.
module battleship_fsm
    import battleship_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic         clk,
    input  logic         clr,
    battleship_if.slave  io
);

    if (REFRESH_BITS < 2) begin : g_bad_cfg
        $error("REFRESH_BITS must be at least 2");
    end

    state_e     state_q, state_d;
    logic       btn1_q, btn2a_q, btn2b_q;
    logic       ev1, ev2a, ev2b;
    logic       ldr2a_d, ldr2b_d;
    logic       ldr2a_q, ldr2b_q;
    logic       st_q, ldr1_q;
    logic [2:0] disp_a_q, disp_b_q;

    assign ev1  = io.BTN1  & ~btn1_q;
    assign ev2a = io.BTN2A & ~btn2a_q;
    assign ev2b = io.BTN2B & ~btn2b_q;

    function automatic logic [2:0] disp_a_of(input state_e s);
        case (s)
            S_TURN_A: return D_FIRE;
            S_TURN_B: return D_WAIT;
            S_WIN_A:  return D_WIN;
            S_WIN_B:  return D_LOSE;
            S_DRAW:   return D_DRAW;
            default:  return D_LOAD;
        endcase
    endfunction

    function automatic logic [2:0] disp_b_of(input state_e s);
        case (s)
            S_TURN_A: return D_WAIT;
            S_TURN_B: return D_FIRE;
            S_WIN_A:  return D_LOSE;
            S_WIN_B:  return D_WIN;
            S_DRAW:   return D_DRAW;
            default:  return D_LOAD;
        endcase
    endfunction

    // Liveness outranks any fire event in the turn states.
    always_comb begin
        state_d = state_q;
        ldr2a_d = 1'b0;
        ldr2b_d = 1'b0;
        unique case (state_q)
            S_SETUP: begin
                if (ev1) state_d = S_TURN_A;
            end
            S_TURN_A, S_TURN_B: begin
                if (!io.LivA && !io.LivB) begin
                    state_d = S_DRAW;
                end else if (!io.LivA) begin
                    state_d = S_WIN_B;
                end else if (!io.LivB) begin
                    state_d = S_WIN_A;
                end else if (state_q == S_TURN_A) begin
                    if (ev2a && io.OKA) begin
                        ldr2a_d = 1'b1;
                        state_d = S_TURN_B;
                    end
                end else if (ev2b && io.OKB) begin
                    ldr2b_d = 1'b1;
                    state_d = S_TURN_A;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_SETUP;
            btn1_q   <= 1'b0;
            btn2a_q  <= 1'b0;
            btn2b_q  <= 1'b0;
            st_q     <= 1'b0;
            ldr1_q   <= 1'b1;
            ldr2a_q  <= 1'b0;
            ldr2b_q  <= 1'b0;
            disp_a_q <= D_LOAD;
            disp_b_q <= D_LOAD;
        end else begin
            state_q  <= state_d;
            btn1_q   <= io.BTN1;
            btn2a_q  <= io.BTN2A;
            btn2b_q  <= io.BTN2B;
            st_q     <= (state_d != S_SETUP);
            ldr1_q   <= (state_d == S_SETUP);
            ldr2a_q  <= ldr2a_d;
            ldr2b_q  <= ldr2b_d;
            disp_a_q <= disp_a_of(state_d);
            disp_b_q <= disp_b_of(state_d);
        end
    end

    assign io.ST    = st_q;
    assign io.LDR1A = ldr1_q;
    assign io.LDR1B = ldr1_q;
    assign io.LDR2A = ldr2a_q;
    assign io.LDR2B = ldr2b_q;
    assign io.DispA = disp_a_q;
    assign io.DispB = disp_b_q;

`ifdef BATTLESHIP_SSEG_EN
    words2 #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_words2 (
        .clk        (clk),
        .clr        (clr),
        .wordSelect (disp_a_q),
        .seg        (io.seg),
        .an         (io.an)
    );
`else
    assign io.seg = 8'hFF;
    assign io.an  = 4'hF;
`endif

endmodule

// File: tb/tb_battleship_fsm.sv
// Bench for battleship_fsm: game-level model checked every cycle plus directed literals.
// Display checks follow BATTLESHIP_SSEG_EN.
module tb_battleship_fsm;

    localparam int RB = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;

    battleship_if bus();

    battleship_fsm #(
        .REFRESH_BITS(RB)
    ) dut (
        .clk (clk),
        .clr (clr),
        .io  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Game model: mode 0 setup, 1 playing, 2 over; result 0 A won, 1 B won, 2 draw.
    int m_mode = 0;
    bit m_turn_b = 0;
    int m_res = 0;
    bit m_p1, m_p2a, m_p2b;
    bit m_ld2a, m_ld2b;
    int m_cnt = 0;
    bit m_valid = 0;

    function automatic logic [2:0] exp_disp(input bit for_b);
        if (m_mode == 0) return 3'd0;
        if (m_mode == 1) return (m_turn_b ^ for_b) ? 3'd2 : 3'd1;
        if (m_res == 2) return 3'd5;
        return ((m_res == 1) ^ for_b) ? 3'd4 : 3'd3;
    endfunction

    function automatic logic [7:0] seg_of(input byte c);
        case (c)
            "L": return 8'hC7;
            "O": return 8'hC0;
            "A": return 8'h88;
            "D": return 8'hA1;
            "d": return 8'hA1;
            "F": return 8'h8E;
            "I": return 8'hF9;
            "r": return 8'hAF;
            "E": return 8'h86;
            "W": return 8'hC1;
            "t": return 8'h87;
            "N": return 8'hC8;
            "S": return 8'h92;
            default: return 8'hFF;
        endcase
    endfunction

    string words[8] = '{"LOAD", "FIrE", "WAIt", " WIN",
                        "LOSE", "drAW", "    ", "    "};

    always @(posedge clk) begin
        bit e1, e2a, e2b;
        if (clr) begin
            m_mode = 0; m_turn_b = 0;
            m_p1 = 0; m_p2a = 0; m_p2b = 0;
            m_ld2a = 0; m_ld2b = 0;
            m_cnt = 0; m_valid = 1;
        end else if (m_valid) begin
            e1  = bus.BTN1  && !m_p1;
            e2a = bus.BTN2A && !m_p2a;
            e2b = bus.BTN2B && !m_p2b;
            m_ld2a = 0; m_ld2b = 0;
            if (m_mode == 0) begin
                if (e1) begin m_mode = 1; m_turn_b = 0; end
            end else if (m_mode == 1) begin
                if (!bus.LivA || !bus.LivB) begin
                    m_mode = 2;
                    m_res = (!bus.LivA && !bus.LivB) ? 2 : (!bus.LivA ? 1 : 0);
                end else if (!m_turn_b && e2a && bus.OKA) begin
                    m_ld2a = 1; m_turn_b = 1;
                end else if (m_turn_b && e2b && bus.OKB) begin
                    m_ld2b = 1; m_turn_b = 0;
                end
            end
            m_p1 = bus.BTN1; m_p2a = bus.BTN2A; m_p2b = bus.BTN2B;
            m_cnt = (m_cnt + 1) % (1 << RB);
        end
        #1;
        if (m_valid) begin
            int dg;
            string w;
            chk("ST", bus.ST, m_mode != 0);
            chk("LDR1A", bus.LDR1A, m_mode == 0);
            chk("LDR1B", bus.LDR1B, m_mode == 0);
            chk("LDR2A", bus.LDR2A, m_ld2a);
            chk("LDR2B", bus.LDR2B, m_ld2b);
            chk("DispA", bus.DispA, exp_disp(0));
            chk("DispB", bus.DispB, exp_disp(1));
`ifdef BATTLESHIP_SSEG_EN
            dg = (m_cnt >> (RB - 2)) & 3;
            w = words[exp_disp(0)];
            chk("an", bus.an, 4'hF ^ (4'h1 << dg));
            chk("seg", bus.seg, seg_of(w[3 - dg]));
`else
            dg = 0;
            w = "";
            chk("an", bus.an, 4'hF);
            chk("seg", bus.seg, 8'hFF);
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic enter_turn_a();
        clr = 1; tick(); clr = 0;
        bus.BTN1 = 1; tick(); bus.BTN1 = 0;
    endtask

    initial begin
        bus.BTN1 = 0; bus.BTN2A = 0; bus.BTN2B = 0;
        bus.LivA = 1; bus.LivB = 1; bus.OKA = 0; bus.OKB = 0;

        clr = 1; tick();
        chk("rst_ST", bus.ST, 1'b0);
        chk("rst_DispA", bus.DispA, 3'd0);
        chk("rst_DispB", bus.DispB, 3'd0);
        chk("rst_LDR2", {bus.LDR2A, bus.LDR2B}, 2'b00);
        chk("rst_LDR1", {bus.LDR1A, bus.LDR1B}, 2'b11);
`ifdef BATTLESHIP_SSEG_EN
        chk("rst_an", bus.an, 4'b1110);
`else
        chk("rst_an_off", bus.an, 4'hF);
`endif
        clr = 0;

        bus.BTN1 = 1; tick();
        chk("setup_ST", bus.ST, 1'b1);
        chk("setup_Disp", {bus.DispA, bus.DispB}, {3'd1, 3'd2});
        tick(4);
        chk("setup_hold", {bus.DispA, bus.DispB}, {3'd1, 3'd2});
        bus.BTN1 = 0;

        bus.BTN2A = 1; bus.OKA = 0; tick();
        chk("illegal_LDR2A", bus.LDR2A, 1'b0);
        chk("illegal_stay", bus.DispA, 3'd1);
        bus.BTN2A = 0; tick();
        bus.BTN2A = 1; bus.OKA = 1; tick();
        chk("fire_LDR2A", bus.LDR2A, 1'b1);
        chk("fire_Disp", {bus.DispA, bus.DispB}, {3'd2, 3'd1});
        tick();
        chk("fire_pulse_end", bus.LDR2A, 1'b0);
        bus.BTN2A = 0; tick();

        bus.BTN2A = 1; tick();
        chk("wrong_player", bus.DispA, 3'd2);
        bus.BTN2A = 0; bus.OKA = 0;

        bus.BTN2B = 1; bus.OKB = 1; tick();
        chk("fire_LDR2B", bus.LDR2B, 1'b1);
        chk("back_to_A", bus.DispA, 3'd1);
        bus.BTN2B = 0;
        bus.BTN2A = 1; bus.OKA = 1; tick();
        bus.BTN2A = 0; tick();

        bus.LivA = 0; bus.BTN2B = 1; tick();
        chk("winB_Disp", {bus.DispA, bus.DispB}, {3'd4, 3'd3});
        chk("winB_noLDR2B", bus.LDR2B, 1'b0);
        bus.LivA = 1; bus.BTN2B = 0; tick(2);
        chk("winB_sticky", bus.DispA, 3'd4);
        clr = 1; tick(); clr = 0;
        chk("clr_after_win", {bus.ST, bus.DispA}, {1'b0, 3'd0});

        enter_turn_a();
        bus.LivA = 0; bus.LivB = 0; tick();
        chk("draw_Disp", {bus.DispA, bus.DispB}, {3'd5, 3'd5});
        bus.LivA = 1; bus.LivB = 1;

        enter_turn_a();
        bus.LivB = 0; bus.BTN2A = 1; bus.OKA = 1; tick();
        chk("winA_Disp", {bus.DispA, bus.DispB}, {3'd3, 3'd4});
        chk("winA_noLDR2A", bus.LDR2A, 1'b0);
        bus.LivB = 1; bus.BTN2A = 0; bus.OKA = 0;

        enter_turn_a();
        bus.BTN2A = 1; bus.OKA = 1; clr = 1; tick();
        chk("clr_midturn", {bus.ST, bus.LDR2A, bus.DispA}, {1'b0, 1'b0, 3'd0});
        bus.BTN2A = 0; bus.OKA = 0;

        clr = 1; tick(); clr = 0;
        tick(12);
`ifdef BATTLESHIP_SSEG_EN
        chk("sweep_left_an", bus.an, 4'b0111);
        chk("sweep_left_L", bus.seg, 8'hC7);
`else
        chk("sweep_off_seg", bus.seg, 8'hFF);
`endif
        tick(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=1 want=0");
        $fatal(1, "timeout");
    end

endmodule
